// File: rtl/ddr4_cmd_sequencer.sv
// DDR4 command sequencer: open-page row tracking, tRCD/tRP/tRFC spacing, periodic refresh, CL read return.
// Define AUTO_PRECHARGE_EN for closed-page operation (A10=1 on RD/WR, no PRE/PREA issued).
module ddr4_cmd_sequencer #(
  parameter int T_RCD  = 4,
  parameter int T_RP   = 4,
  parameter int T_RFC  = 16,
  parameter int T_REFI = 780,
  parameter int CL     = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_bg,
  input  logic [1:0]  req_ba,
  input  logic [16:0] req_row,
  input  logic [9:0]  req_col,
  input  logic [15:0] req_wdata,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        cmd_act_n,
  output logic        cmd_refresh,
  output logic        cmd_bg,
  output logic [1:0]  cmd_ba,
  output logic [16:0] cmd_addr,
  output logic [15:0] cmd_wdata,
  input  logic [15:0] cmd_rdata,
  output logic        busy
);

`ifdef AUTO_PRECHARGE_EN
  localparam logic AP = 1'b1;
`else
  localparam logic AP = 1'b0;
`endif

  localparam int CNT_W = 16;
  localparam int REF_W = $clog2(T_REFI);
  localparam logic [16:0] ADDR_NOP  = 17'h1C000;
  localparam logic [16:0] ADDR_PRE  = 17'h08000;
  localparam logic [16:0] ADDR_PREA = 17'h08400;
  // Wait states hold for LOAD+1 cycles, so a spacing of T uses T-2 (wait skipped when T==1).
  localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'((T_RCD > 1) ? T_RCD - 2 : 0);
  localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'((T_RP  > 1) ? T_RP  - 2 : 0);
  localparam logic [CNT_W-1:0] RFC_LOAD = CNT_W'((T_RFC > 1) ? T_RFC - 2 : 0);
  localparam logic [CNT_W-1:0] AP_LOAD  = CNT_W'(T_RP - 1);
  localparam logic [REF_W-1:0] REFI_LAST = REF_W'(T_REFI - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_PRE_WAIT, S_ACT, S_ACT_WAIT, S_RW,
    S_PREA, S_PREA_WAIT, S_REF, S_REF_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REF_W-1:0]  ref_cnt_q;
  logic              ref_pending_q;
  logic [7:0]        tbl_vld_q;
  logic [16:0]       tbl_row_q [8];

  logic              lat_we_q, lat_bg_q;
  logic [1:0]        lat_ba_q;
  logic [16:0]       lat_row_q;
  logic [9:0]        lat_col_q;
  logic [15:0]       lat_wdata_q;

  logic              act_n_q, refresh_q, bg_q;
  logic [1:0]        ba_q;
  logic [16:0]       addr_q;
  logic [15:0]       wdata_q;
  logic [CL-1:0]     rd_pipe_q;
  logic              rd_valid_q;
  logic [15:0]       rd_data_q;

  logic              accept, hit, ref_wrap, rd_push;
  logic [2:0]        req_bank, sel_bank;
  logic              sel_we, sel_bg;
  logic [1:0]        sel_ba;
  logic [16:0]       sel_row;
  logic [9:0]        sel_col;
  logic [15:0]       sel_wdata;

  assign req_ready = (state_q == S_IDLE) & ~ref_pending_q & ~reset;
  assign busy      = (state_q != S_IDLE) | ref_pending_q;
  assign accept    = req_valid & req_ready;
  assign req_bank  = {req_bg, req_ba};
  assign hit       = tbl_vld_q[req_bank] & (tbl_row_q[req_bank] == req_row);
  assign ref_wrap  = (ref_cnt_q == REFI_LAST);

  // Commands are registered on the edge that enters their state, so the accepted request is used directly.
  assign sel_we    = accept ? req_we    : lat_we_q;
  assign sel_bg    = accept ? req_bg    : lat_bg_q;
  assign sel_ba    = accept ? req_ba    : lat_ba_q;
  assign sel_row   = accept ? req_row   : lat_row_q;
  assign sel_col   = accept ? req_col   : lat_col_q;
  assign sel_wdata = accept ? req_wdata : lat_wdata_q;
  assign sel_bank  = {sel_bg, sel_ba};
  assign rd_push   = (state_d == S_RW) & ~sel_we;

  assign cmd_act_n   = act_n_q;
  assign cmd_refresh = refresh_q;
  assign cmd_bg      = bg_q;
  assign cmd_ba      = ba_q;
  assign cmd_addr    = addr_q;
  assign cmd_wdata   = wdata_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (ref_pending_q) begin
          state_d = (|tbl_vld_q) ? S_PREA : S_REF;
        end else if (accept) begin
          if (hit)                      state_d = S_RW;
          else if (tbl_vld_q[req_bank]) state_d = S_PRE;
          else                          state_d = S_ACT;
        end
      end
      S_PRE: begin
        if (T_RP > 1) begin state_d = S_PRE_WAIT; cnt_d = RP_LOAD; end
        else state_d = S_ACT;
      end
      S_PRE_WAIT: begin
        if (cnt_q == '0) state_d = AP ? S_IDLE : S_ACT;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      S_ACT: begin
        if (T_RCD > 1) begin state_d = S_ACT_WAIT; cnt_d = RCD_LOAD; end
        else state_d = S_RW;
      end
      S_ACT_WAIT: begin
        if (cnt_q == '0) state_d = S_RW;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      S_RW: begin
        if (AP) begin state_d = S_PRE_WAIT; cnt_d = AP_LOAD; end
        else state_d = S_IDLE;
      end
      S_PREA: begin
        if (T_RP > 1) begin state_d = S_PREA_WAIT; cnt_d = RP_LOAD; end
        else state_d = S_REF;
      end
      S_PREA_WAIT: begin
        if (cnt_q == '0) state_d = S_REF;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      S_REF: begin
        if (T_RFC > 1) begin state_d = S_REF_WAIT; cnt_d = RFC_LOAD; end
        else state_d = S_IDLE;
      end
      S_REF_WAIT: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      ref_cnt_q     <= '0;
      ref_pending_q <= 1'b0;
      tbl_vld_q     <= '0;
      tbl_row_q     <= '{default: '0};
      lat_we_q      <= 1'b0;
      lat_bg_q      <= 1'b0;
      lat_ba_q      <= '0;
      lat_row_q     <= '0;
      lat_col_q     <= '0;
      lat_wdata_q   <= '0;
      act_n_q       <= 1'b1;
      refresh_q     <= 1'b0;
      bg_q          <= 1'b0;
      ba_q          <= '0;
      addr_q        <= ADDR_NOP;
      wdata_q       <= '0;
      rd_pipe_q     <= '0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_cnt_q <= ref_wrap ? '0 : ref_cnt_q + REF_W'(1);
      if (ref_wrap)              ref_pending_q <= 1'b1;
      else if (state_d == S_REF) ref_pending_q <= 1'b0;

      if (accept) begin
        lat_we_q    <= req_we;
        lat_bg_q    <= req_bg;
        lat_ba_q    <= req_ba;
        lat_row_q   <= req_row;
        lat_col_q   <= req_col;
        lat_wdata_q <= req_wdata;
      end

      rd_pipe_q  <= (rd_pipe_q << 1) | CL'(rd_push);
      rd_valid_q <= rd_pipe_q[CL-1];
      if (rd_pipe_q[CL-1]) rd_data_q <= cmd_rdata;

      act_n_q   <= 1'b1;
      refresh_q <= 1'b0;
      addr_q    <= ADDR_NOP;
      unique case (state_d)
        S_PRE: begin
          addr_q              <= ADDR_PRE;
          bg_q                <= sel_bg;
          ba_q                <= sel_ba;
          tbl_vld_q[sel_bank] <= 1'b0;
        end
        S_ACT: begin
          act_n_q <= 1'b0;
          addr_q  <= sel_row;
          bg_q    <= sel_bg;
          ba_q    <= sel_ba;
          if (!AP) begin
            tbl_vld_q[sel_bank] <= 1'b1;
            tbl_row_q[sel_bank] <= sel_row;
          end
        end
        S_RW: begin
          addr_q <= {1'b1, 1'b0, ~sel_we, 3'b000, AP, sel_col};
          bg_q   <= sel_bg;
          ba_q   <= sel_ba;
          if (sel_we) wdata_q <= sel_wdata;
        end
        S_PREA: begin
          addr_q    <= ADDR_PREA;
          bg_q      <= 1'b0;
          ba_q      <= '0;
          tbl_vld_q <= '0;
        end
        S_REF: refresh_q <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr4_cmd_sequencer.sv
// Directed bench for ddr4_cmd_sequencer: request vector table plus hand-written refresh and reset sequences.
module tb_ddr4_cmd_sequencer;
  localparam int T_RCD = 4, T_RP = 4, T_RFC = 16, T_REFI = 780, CL = 5;
  localparam int P_HIT = 0, P_ACT = 1, P_PRE = 2;
  localparam logic [16:0] NOP_ADDR = 17'h1C000;

  logic clk = 1'b0;
  logic reset, req_valid, req_ready, req_we, req_bg;
  logic [1:0] req_ba;
  logic [16:0] req_row;
  logic [9:0] req_col;
  logic [15:0] req_wdata;
  logic rd_valid, cmd_act_n, cmd_refresh, cmd_bg, busy;
  logic [15:0] rd_data, cmd_wdata, cmd_rdata;
  logic [1:0] cmd_ba;
  logic [16:0] cmd_addr;
  logic [31:0] cyc = 0;

  int total = 0;
  int bad = 0;
  logic [31:0] r0;
  logic [15:0] last_wd = 16'h0;

  typedef struct {
    logic we; logic bg; logic [1:0] ba; logic [16:0] row; logic [9:0] col;
    logic [15:0] wd; int path; logic [16:0] rw_addr;
  } vec_t;
  typedef struct { logic [31:0] cyc; logic [15:0] data; } rd_exp_t;

  vec_t vecs [12];
  rd_exp_t exp_q [$];
  rd_exp_t mon_e;

  ddr4_cmd_sequencer #(.T_RCD(T_RCD), .T_RP(T_RP), .T_RFC(T_RFC), .T_REFI(T_REFI), .CL(CL)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .cmd_act_n(cmd_act_n), .cmd_refresh(cmd_refresh),
    .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_rdata(cmd_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Controller stand-in: data_out changes every cycle, so a mis-timed sample shows up as wrong data.
  assign cmd_rdata = cyc[15:0] ^ 16'hA5A5;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input logic [31:0] target);
    if (cyc > target) chk("schedule", cyc, target);
    while (cyc < target) step();
  endtask

  task automatic nop_wait(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("gap_addr", cmd_addr, NOP_ADDR);
      chk("gap_act_n", cmd_act_n, 1);
    end
    step();
  endtask

  task automatic do_req(input vec_t v);
    logic [31:0] t;
    req_valid = 1'b1; req_we = v.we; req_bg = v.bg; req_ba = v.ba;
    req_row = v.row; req_col = v.col; req_wdata = v.wd;
    chk("accept_ready", req_ready, 1);
    step();
    req_valid = 1'b0; req_we = ~v.we; req_bg = ~v.bg; req_ba = ~v.ba;
    req_row = ~v.row; req_col = ~v.col; req_wdata = ~v.wd;
    if (v.path == P_PRE) begin
      chk("pre_addr", cmd_addr, 17'h08000);
      chk("pre_act_n", cmd_act_n, 1);
      chk("pre_bank", {cmd_bg, cmd_ba}, {v.bg, v.ba});
      nop_wait(T_RP - 1);
    end
    if (v.path != P_HIT) begin
      chk("act_act_n", cmd_act_n, 0);
      chk("act_addr", cmd_addr, v.row);
      chk("act_bank", {cmd_bg, cmd_ba}, {v.bg, v.ba});
      nop_wait(T_RCD - 1);
    end
    chk("rw_addr", cmd_addr, v.rw_addr);
    chk("rw_act_n", cmd_act_n, 1);
    chk("rw_bank", {cmd_bg, cmd_ba}, {v.bg, v.ba});
    if (v.we) last_wd = v.wd;
    chk("rw_wdata", cmd_wdata, last_wd);
    if (!v.we) begin
      t = cyc + CL - 1;
      exp_q.push_back('{cyc + CL, t[15:0] ^ 16'hA5A5});
    end
    step();
    chk("post_rw_nop", cmd_addr, NOP_ADDR);
  endtask

  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) chk("rd_spurious", rd_valid, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("rd_cycle", cyc, mon_e.cyc);
        chk("rd_data", rd_data, mon_e.data);
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      mon_e = exp_q.pop_front();
      chk("rd_missing", 0, 1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_bg = 1'b0; req_ba = 2'd0;
    req_row = 17'h0; req_col = 10'h0; req_wdata = 16'h0;

    vecs[0]  = '{1'b1, 1'b0, 2'd0, 17'h00017, 10'h002, 16'hFF00, P_ACT, 17'h10002};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 17'h00017, 10'h002, 16'h0000, P_HIT, 17'h14002};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 17'h00001, 10'h005, 16'h0000, P_PRE, 17'h14005};
    vecs[3]  = '{1'b1, 1'b1, 2'd3, 17'h1ABCD, 10'h3FF, 16'h1234, P_ACT, 17'h103FF};
    vecs[4]  = '{1'b0, 1'b1, 2'd3, 17'h1ABCD, 10'h155, 16'h0000, P_HIT, 17'h14155};
    vecs[5]  = '{1'b1, 1'b0, 2'd0, 17'h00001, 10'h007, 16'hBEEF, P_HIT, 17'h10007};
    vecs[6]  = '{1'b0, 1'b1, 2'd3, 17'h00000, 10'h000, 16'h0000, P_PRE, 17'h14000};
    vecs[7]  = '{1'b0, 1'b1, 2'd2, 17'h1FFFF, 10'h200, 16'h0000, P_ACT, 17'h14200};
    vecs[8]  = '{1'b1, 1'b1, 2'd2, 17'h1FFFF, 10'h001, 16'h0000, P_HIT, 17'h10001};
    vecs[9]  = '{1'b1, 1'b1, 2'd3, 17'h1ABCD, 10'h003, 16'h5555, P_PRE, 17'h10003};
    vecs[10] = '{1'b0, 1'b1, 2'd1, 17'h0A5A5, 10'h0F0, 16'h0000, P_ACT, 17'h140F0};
    vecs[11] = '{1'b0, 1'b1, 2'd1, 17'h0A5A5, 10'h0F1, 16'h0000, P_HIT, 17'h140F1};

    repeat (2) step();
    chk("rst_act_n", cmd_act_n, 1);
    chk("rst_refresh", cmd_refresh, 0);
    chk("rst_addr", cmd_addr, NOP_ADDR);
    chk("rst_bank", {cmd_bg, cmd_ba}, 0);
    chk("rst_wdata", cmd_wdata, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);

    reset = 1'b0;
    r0 = cyc;
    #1;
    chk("ready_after_release", req_ready, 1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_ready", req_ready, 1);
      chk("idle_act_n", cmd_act_n, 1);
      chk("idle_addr", cmd_addr, NOP_ADDR);
      chk("idle_busy", busy, 0);
    end

    for (int i = 0; i < 12; i++) begin
      do_req(vecs[i]);
      chk("vec_ready", req_ready, 1);
    end

    // Refresh with bank 1_1 open: request held while refresh is pending.
    wait_until(r0 + T_REFI - 1);
    chk("pre_wrap_ready", req_ready, 1);
    chk("pre_wrap_busy", busy, 0);
    step();
    req_valid = 1'b1; req_we = 1'b0; req_bg = 1'b1; req_ba = 2'd1;
    req_row = 17'h0A5A5; req_col = 10'h0F2; req_wdata = 16'h0;
    #1;
    chk("pending_ready", req_ready, 0);
    chk("pending_busy", busy, 1);
    step();
    chk("prea_addr", cmd_addr, 17'h08400);
    chk("prea_act_n", cmd_act_n, 1);
    wait_until(r0 + T_REFI + 5);
    chk("ref_strobe", cmd_refresh, 1);
    chk("ref_addr", cmd_addr, NOP_ADDR);
    step();
    chk("ref_one_cycle", cmd_refresh, 0);
    wait_until(r0 + T_REFI + 20);
    chk("ref_wait_ready", req_ready, 0);
    step();
    do_req('{1'b0, 1'b1, 2'd1, 17'h0A5A5, 10'h0F2, 16'h0, P_ACT, 17'h140F2});

    // Second wrap lands on the same edge as an accept: the request goes first.
    wait_until(r0 + 2 * T_REFI - 1);
    do_req('{1'b0, 1'b1, 2'd1, 17'h0A5A5, 10'h0F3, 16'h0, P_HIT, 17'h140F3});
    chk("wrap_accept_ready", req_ready, 0);
    chk("wrap_accept_busy", busy, 1);
    step();
    chk("prea2_addr", cmd_addr, 17'h08400);
    wait_until(r0 + 2 * T_REFI + 6);
    chk("ref2_strobe", cmd_refresh, 1);
    wait_until(r0 + 2 * T_REFI + 22);
    chk("ref2_ready", req_ready, 1);

    // Reset during ACT_WAIT with a read still in the return pipe.
    do_req('{1'b0, 1'b0, 2'd1, 17'h00005, 10'h009, 16'h0, P_ACT, 17'h14009});
    do_req('{1'b0, 1'b0, 2'd1, 17'h00005, 10'h00A, 16'h0, P_HIT, 17'h1400A});
    req_valid = 1'b1; req_we = 1'b1; req_bg = 1'b0; req_ba = 2'd2;
    req_row = 17'h00007; req_col = 10'h0; req_wdata = 16'h7777;
    chk("pre_reset_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("pre_reset_act", cmd_act_n, 0);
    step();
    reset = 1'b1;
    #1;
    exp_q.delete();
    chk("async_act_n", cmd_act_n, 1);
    chk("async_addr", cmd_addr, NOP_ADDR);
    chk("async_wdata", cmd_wdata, 0);
    chk("async_ready", req_ready, 0);
    chk("async_busy", busy, 0);
    chk("async_rd_valid", rd_valid, 0);
    step();
    step();
    reset = 1'b0;
    last_wd = 16'h0;
    for (int i = 0; i < CL + 3; i++) begin
      step();
      chk("post_reset_rd_valid", rd_valid, 0);
      chk("post_reset_act_n", cmd_act_n, 1);
    end
    do_req('{1'b0, 1'b0, 2'd1, 17'h00005, 10'h009, 16'h0, P_ACT, 17'h14009});
    repeat (CL + 2) step();
    chk("rd_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
